// File: rtl/ser_frame_counter.sv
// ser_frame_counter: deframes start/data/stop serial frames, counting good and bad frames.
// Define SER_FRAME_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module ser_frame_counter #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              clr,
   input  logic              serIn,
   output logic              serOutValid,
   output logic [DATA_W-1:0] data,
   output logic [CNT_W-1:0]  nt,
   output logic              frameErr,
   output logic [CNT_W-1:0]  errCnt,
   output logic              busy
);
   localparam int BW = DATA_W > 1 ? $clog2(DATA_W) : 1;
   localparam logic [BW-1:0] LAST = BW'(DATA_W - 1);
   localparam logic [CNT_W-1:0] CMAX = '1;
`ifdef SER_FRAME_PARITY_EN
   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
   localparam state_t AFTER_DATA = PARITY;
`else
   typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;
   localparam state_t AFTER_DATA = STOP;
`endif
   state_t state_q, state_d;
   logic [BW-1:0] bit_cnt_q, bit_cnt_d;
   logic [DATA_W-1:0] sh_q, sh_d, data_q, data_d;
   logic [CNT_W-1:0] nt_q, nt_d, err_cnt_q, err_cnt_d;
   logic valid_q, valid_d, ferr_q, ferr_d, par_err_q, par_err_d, good;
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      sh_d      = sh_q;
      data_d    = data_q;
      nt_d      = nt_q;
      err_cnt_d = err_cnt_q;
      par_err_d = par_err_q;
      valid_d   = 1'b0;
      ferr_d    = 1'b0;
`ifdef SER_FRAME_PARITY_EN
      good      = serIn && !par_err_q;
`else
      good      = serIn;
`endif
      case (state_q)
         IDLE: if (en && !serIn) begin
            state_d   = DATA;
            bit_cnt_d = '0;
         end
         DATA: if (!en) state_d = IDLE;
         else begin
            sh_d[bit_cnt_q] = serIn;
            bit_cnt_d       = bit_cnt_q + 1'b1;
            if (bit_cnt_q == LAST) state_d = AFTER_DATA;
         end
`ifdef SER_FRAME_PARITY_EN
         PARITY: if (!en) state_d = IDLE;
         else begin
            par_err_d = ^{sh_q, serIn};
            state_d   = STOP;
         end
`endif
         STOP: begin
            state_d = IDLE;
            if (en && good) begin
               data_d  = sh_q;
               valid_d = 1'b1;
               nt_d    = nt_q == CMAX ? nt_q : nt_q + 1'b1;
            end else if (en) begin
               ferr_d    = 1'b1;
               err_cnt_d = err_cnt_q == CMAX ? err_cnt_q : err_cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      // clear wins over a same-edge increment
      if (clr) begin
         nt_d      = '0;
         err_cnt_d = '0;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         sh_q      <= '0;
         data_q    <= '0;
         nt_q      <= '0;
         err_cnt_q <= '0;
         par_err_q <= 1'b0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         sh_q      <= sh_d;
         data_q    <= data_d;
         nt_q      <= nt_d;
         err_cnt_q <= err_cnt_d;
         par_err_q <= par_err_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
      end
   end
   assign serOutValid = valid_q;
   assign frameErr    = ferr_q;
   assign data        = data_q;
   assign nt          = nt_q;
   assign errCnt      = err_cnt_q;
   assign busy        = state_q != IDLE;
endmodule

// File: tb/tb_ser_frame_counter.sv
// tb_ser_frame_counter: directed and random frames against a frame-level model, two counter widths.
module tb_ser_frame_counter;
   logic clk = 1'b0, rst, en, clr, serIn;
   logic sv1, fe1, busy1, sv2, fe2, busy2;
   logic [7:0] data1, data2, nt1, err1;
   logic [1:0] nt2, err2;
   int compared = 0, mismatched = 0;
   int good_total = 0, err_total = 0;
   logic [7:0] exp_data = '0;
`ifdef SER_FRAME_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif
   always #5 clk = ~clk;
   ser_frame_counter #(.DATA_W(8), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .en(en), .clr(clr), .serIn(serIn), .serOutValid(sv1),
      .data(data1), .nt(nt1), .frameErr(fe1), .errCnt(err1), .busy(busy1));
   ser_frame_counter #(.DATA_W(8), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .en(en), .clr(clr), .serIn(serIn), .serOutValid(sv2),
      .data(data2), .nt(nt2), .frameErr(fe2), .errCnt(err2), .busy(busy2));
   function automatic int sat(input int t, input int m);
      return t > m ? m : t;
   endfunction
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic chk_all(input string tag, input bit v, input bit fe, input bit b);
      chk({tag, ".valid"}, 32'(sv1), 32'(v));
      chk({tag, ".frameErr"}, 32'(fe1), 32'(fe));
      chk({tag, ".busy"}, 32'(busy1), 32'(b));
      chk({tag, ".data"}, 32'(data1), 32'(exp_data));
      chk({tag, ".nt"}, 32'(nt1), sat(good_total, 255));
      chk({tag, ".errCnt"}, 32'(err1), sat(err_total, 255));
      chk({tag, ".valid2"}, 32'(sv2), 32'(v));
      chk({tag, ".frameErr2"}, 32'(fe2), 32'(fe));
      chk({tag, ".nt2"}, 32'(nt2), sat(good_total, 3));
      chk({tag, ".errCnt2"}, 32'(err2), sat(err_total, 3));
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic send_frame(input logic [7:0] d, input bit stop, input bit pflip, input bit clr_stop);
      bit good;
      en = 1'b1;
      serIn = 1'b0;
      tick;
      chk_all("start", 0, 0, 1);
      for (int i = 0; i < 8; i++) begin
         serIn = d[i];
         tick;
         chk_all("data", 0, 0, 1);
      end
      if (PAR) begin
         serIn = (^d) ^ pflip;
         tick;
         chk_all("parity", 0, 0, 1);
      end
      serIn = stop;
      clr = clr_stop;
      tick;
      clr = 1'b0;
      serIn = 1'b1;
      good = stop && !(PAR && pflip);
      if (good) begin
         exp_data = d;
         good_total++;
      end else err_total++;
      if (clr_stop) begin
         good_total = 0;
         err_total = 0;
      end
      chk_all("stop", good, !good, 0);
   endtask
   task automatic abort_frame(input int k);
      en = 1'b1;
      serIn = 1'b0;
      tick;
      chk_all("ab_start", 0, 0, 1);
      for (int i = 0; i < k; i++) begin
         serIn = 1'($urandom);
         tick;
         chk_all("ab_data", 0, 0, 1);
      end
      en = 1'b0;
      tick;
      chk_all("abort", 0, 0, 0);
      serIn = 1'b1;
   endtask
   initial begin
      rst = 1'b1;
      en = 1'b0;
      clr = 1'b0;
      serIn = 1'b1;
      repeat (2) tick;
      chk_all("reset", 0, 0, 0);
      rst = 1'b0;
      en = 1'b1;
      repeat (20) begin
         tick;
         chk_all("idle", 0, 0, 0);
      end
      send_frame(8'hA5, 1, 0, 0);
      send_frame(8'h3C, 0, 0, 0);
      send_frame(8'h01, 1, 0, 0);
      send_frame(8'hFF, 1, 0, 0);
      abort_frame(4);
      serIn = 1'b0;
      repeat (6) begin
         tick;
         chk_all("en_low", 0, 0, 0);
      end
      serIn = 1'b1;
      for (int i = 0; i < 3; i++) send_frame(8'($urandom), 1, 0, 0);
      send_frame(8'h5A, 1, 0, 1);
      if (PAR) send_frame(8'hA5, 1, 1, 0);
      en = 1'b1;
      serIn = 1'b0;
      tick;
      serIn = 1'b1;
      tick;
      rst = 1'b1;
      #1;
      good_total = 0;
      err_total = 0;
      exp_data = '0;
      chk_all("async_rst", 0, 0, 0);
      tick;
      rst = 1'b0;
      tick;
      chk_all("post_rst", 0, 0, 0);
      for (int n = 0; n < 40; n++) begin
         int r;
         repeat ($urandom_range(0, 2)) begin
            tick;
            chk_all("gap", 0, 0, 0);
         end
         r = $urandom_range(0, 9);
         if (r == 0) abort_frame($urandom_range(0, 7));
         else send_frame(8'($urandom), r != 1, r == 2, r == 3);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/ser_frame_counter.md
Name: ser_frame_counter

Overview:
- Parametrised successor of the serial frame counter.
- Watches a 1-bit serial line (`serIn`) while enabled and deframes start/data/stop frames of configurable width.
- For each good frame: presents the received word, pulses `serOutValid` and increments a saturating frame count `nt`.
- Counts framing errors separately, supports synchronous clear of both counters, and sits between a serial source and downstream word-wide logic.

Parameters:
- DATA_W, 8, data bits per frame, LSB first; legal range 1..32.
- CNT_W, 8, width of `nt` and `errCnt`; both saturate at 2^CNT_W-1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  receive enable; frames are only started and continued while high.
- clr  input  1  synchronous clear of `nt` and `errCnt`.
- serIn  input  1  serial data line; idle level 1.
- serOutValid  output  1  one-cycle pulse when `data` holds a new good frame.
- data  output  DATA_W  last good frame's payload; held between frames.
- nt  output  CNT_W  good-frame count.
- frameErr  output  1  one-cycle pulse on a bad stop bit (or parity error when enabled).
- errCnt  output  CNT_W  error-frame count.
- busy  output  1  high while the FSM is not in IDLE.

Behaviour:
- Reset (async, rst=1) clears everything immediately:
  - FSM to IDLE.
  - `serOutValid`, `frameErr`, `busy` = 0.
  - `data`, `nt`, `errCnt`, shift register and bit counter = 0.
- FSM states: IDLE, DATA, (PARITY, only with the optional feature), STOP. The only other outputs (`serOutValid`, `frameErr`) are registered pulses.
- IDLE:
  - If en=1 and serIn=0 on an edge (start bit), go to DATA with bitCnt=0.
  - Otherwise stay.
- DATA:
  - Each edge, shift serIn into bit position bitCnt (LSB first) and increment bitCnt.
  - When bitCnt reaches DATA_W-1 on the current sample, go to STOP (or PARITY).
- STOP, serIn=1 (good frame):
  - `data` <= shift register.
  - `serOutValid` high for exactly the next cycle.
  - `nt` increments unless saturated.
- STOP, serIn=0 (bad stop):
  - `frameErr` high for exactly the next cycle; `errCnt` increments unless saturated.
  - `data` and `nt` are unchanged.
- After STOP the FSM always returns to IDLE. Back-to-back frames are allowed: a start bit can be accepted on the edge right after the STOP edge.
- Latency: start-bit edge = cycle 0, data bits on cycles 1..DATA_W, stop on cycle DATA_W+1; `serOutValid`/`frameErr` are high during cycle DATA_W+2.
- `busy` = 1 in every state except IDLE.
- en=0 mid-frame:
  - Abort to IDLE on that edge and discard the partial frame.
  - No pulse and no counter change.
  - A pulse already scheduled from a completed STOP still occurs.
- en=0 in IDLE: start bits are ignored.
- clr:
  - clr=1 forces `nt` and `errCnt` to 0 on that edge.
  - On the same edge as an increment, clr wins (result 0).
  - clr does not affect the FSM, `data`, or pulses.
- Saturation: at 2^CNT_W-1 a counter holds its value; the `serOutValid`/`frameErr` pulse is still produced.
- Mid-operation reset: immediate async clear; the next frame must begin with a fresh start bit after rst falls.

Optional Feature:
- Macro: SER_FRAME_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP, sampling one even-parity bit (XOR of data bits and parity bit must equal 0).
  - A parity mismatch with a valid stop bit is an error frame: `frameErr` pulse, `errCnt`++, `data`/`nt` unchanged.
  - A bad stop bit is an error frame regardless of parity.
  - Latency grows by one cycle: pulse during cycle DATA_W+3.
- Undefined: no PARITY state; behaviour exactly as above.

Test Plan (DATA_W=8, CNT_W=8 unless noted):
- Reset then idle: rst pulse, serIn=1, en=1 for 20 cycles -> all outputs 0, `busy`=0 throughout.
- Good frame: en=1, serIn sequence 0, then 1,0,1,0,0,1,0,1 (0xA5 LSB first), then 1 -> `serOutValid` high one cycle at cycle 10, `data`=0xA5, `nt`=1, `busy` high cycles 1..9.
- Framing error then back-to-back good frames: frame 0x3C with stop=0, then 0x01 and 0xFF with no idle gap -> one `frameErr` pulse, `errCnt`=1, `data`=0xFF, `nt`=2; `data`=0x01 visible after the first good pulse.
- Abort and enable gating: en drops after 4 data bits; then start bits with en=0 -> no pulses, counters unchanged, `busy`=0 the cycle after en falls.
- Saturation and clr: CNT_W=2, send 5 good frames -> `nt`=3 after the 3rd and stays 3, with 5 pulses seen; assert clr on the cycle of a `nt` increment -> `nt`=0.
- SER_FRAME_PARITY_EN defined:
  - 0xA5 with parity bit 0 and stop 1 -> good frame, pulse at cycle 11.
  - 0xA5 with parity bit 1 -> `frameErr` pulse, `errCnt`=1, `nt` unchanged.
